// File: rtl/multi_channel_control.sv
// multi_channel_control: SPI-driven command decoder steering per-channel TX/RX
// coax word engines and a bank of per-channel 8-bit control registers.
// Optional feature macro: CONTROL_TX_AUTOSTART_EN (auto-start TX while the
// SPI chip select is inactive).
module multi_channel_control #(
  parameter int         CHANNELS        = 2,
  parameter int         DATA_WIDTH      = 10,
  parameter logic [7:0] DEFAULT_CONTROL = 8'h48
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           spi_cs_n,
  input  logic [7:0]                     spi_rx_data,
  input  logic                           spi_rx_strobe,
  output logic [7:0]                     spi_tx_data,
  output logic                           spi_tx_strobe,
  output logic [CHANNELS-1:0]            tx_reset,
  input  logic [CHANNELS-1:0]            tx_active,
  output logic [DATA_WIDTH-1:0]          tx_data,
  output logic [CHANNELS-1:0]            tx_load_strobe,
  output logic [CHANNELS-1:0]            tx_start_strobe,
  input  logic [CHANNELS-1:0]            tx_empty,
  input  logic [CHANNELS-1:0]            tx_full,
  output logic [CHANNELS-1:0]            rx_reset,
  input  logic [CHANNELS-1:0]            rx_active,
  input  logic [CHANNELS-1:0]            rx_error,
  input  logic [CHANNELS*DATA_WIDTH-1:0] rx_data,
  output logic [CHANNELS-1:0]            rx_read_strobe,
  input  logic [CHANNELS-1:0]            rx_empty,
  output logic [CHANNELS*8-1:0]          control
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] RD1   = 4'd1;
  localparam logic [3:0] RD2   = 4'd2;
  localparam logic [3:0] WR1   = 4'd3;
  localparam logic [3:0] WR2   = 4'd4;
  localparam logic [3:0] TX1   = 4'd5;
  localparam logic [3:0] TX2   = 4'd6;
  localparam logic [3:0] TX3   = 4'd7;
  localparam logic [3:0] RX1   = 4'd8;
  localparam logic [3:0] RX2   = 4'd9;
  localparam logic [3:0] RX3   = 4'd10;
  localparam logic [3:0] RX4   = 4'd11;
  localparam logic [3:0] START = 4'd12;
  localparam logic [3:0] RESET = 4'd13;

  logic                     cs_meta_reg, cs_sync_reg;
  logic                     cs_high;
  logic [3:0]               state_reg, state_next;
  logic [1:0]               ch_reg, ch_next;
  logic [1:0]               reg_sel_reg, reg_sel_next;
  logic [7:0]               mask_reg, mask_next;
  logic                     word_valid_reg, word_valid_next;
  logic [15:0]              rx_buf_reg, rx_buf_next;
  logic [CHANNELS*8-1:0]    control_reg, control_next;
  logic [CHANNELS-1:0]      tx_complete_reg, tx_complete_next;
  logic [CHANNELS-1:0]      tx_active_d_reg;
  logic [CHANNELS-1:0]      tx_clear;
  logic [7:0]               spi_tx_data_reg, spi_tx_data_next;
  logic                     spi_tx_strobe_reg, spi_tx_strobe_next;
  logic [DATA_WIDTH-1:0]    tx_data_reg, tx_data_next;
  logic [CHANNELS-1:0]      tx_load_reg, tx_load_next;
  logic [CHANNELS-1:0]      tx_start_reg, tx_start_next;
  logic [CHANNELS-1:0]      tx_reset_reg, tx_reset_next;
  logic [CHANNELS-1:0]      rx_reset_reg, rx_reset_next;
  logic [CHANNELS-1:0]      rx_read_reg, rx_read_next;

  // One-hot decode of the addressed channel; all zero for an absent channel,
  // which turns every per-channel action into a no-op.
  logic [CHANNELS-1:0] ch_sel;
  logic                ch_ok;
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_sel
    assign ch_sel[gi] = (int'(ch_reg) == gi);
  end
  assign ch_ok   = |ch_sel;
  assign cs_high = cs_sync_reg;

  logic                  full_sel, empty_sel, active_sel, complete_sel;
  logic                  rx_error_sel, rx_active_sel, rx_empty_sel;
  logic [DATA_WIDTH-1:0] rx_data_sel;
  logic [7:0]            control_sel, read_byte;

  // Mux the addressed channel's status inputs and registers.
  always_comb begin
    full_sel      = 1'b0;
    empty_sel     = 1'b1;
    active_sel    = 1'b0;
    complete_sel  = 1'b0;
    rx_error_sel  = 1'b0;
    rx_active_sel = 1'b0;
    rx_empty_sel  = 1'b1;
    rx_data_sel   = '0;
    control_sel   = 8'h00;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel[i]) begin
        full_sel      = tx_full[i];
        empty_sel     = tx_empty[i];
        active_sel    = tx_active[i];
        complete_sel  = tx_complete_reg[i];
        rx_error_sel  = rx_error[i];
        rx_active_sel = rx_active[i];
        rx_empty_sel  = rx_empty[i];
        rx_data_sel   = rx_data[i*DATA_WIDTH +: DATA_WIDTH];
        control_sel   = control_reg[i*8 +: 8];
      end
    end
    read_byte = 8'h00;
    if (ch_ok) begin
      case (reg_sel_reg)
        2'd1:    read_byte = {1'b0, rx_error_sel, rx_active_sel, 1'b0,
                              complete_sel, active_sel, 2'b00};
        2'd2:    read_byte = control_sel;
        2'd3:    read_byte = 8'hA5;
        default: read_byte = 8'h00;
      endcase
    end
  end

  // Command FSM: next state, register updates and single-cycle strobes.
  always_comb begin
    state_next         = state_reg;
    ch_next            = ch_reg;
    reg_sel_next       = reg_sel_reg;
    mask_next          = mask_reg;
    word_valid_next    = word_valid_reg;
    rx_buf_next        = rx_buf_reg;
    control_next       = control_reg;
    tx_data_next       = tx_data_reg;
    spi_tx_data_next   = spi_tx_data_reg;
    spi_tx_strobe_next = 1'b0;
    tx_load_next       = '0;
    tx_start_next      = '0;
    tx_reset_next      = '0;
    rx_reset_next      = '0;
    rx_read_next       = '0;
    tx_clear           = '0;
    if (cs_high) begin
      // Deselect aborts whatever was in flight, with no strobes from it.
      state_next = IDLE;
`ifdef CONTROL_TX_AUTOSTART_EN
      tx_start_next = ~tx_empty & ~tx_active;
`endif
    end else begin
      case (state_reg)
        IDLE: if (spi_rx_strobe) begin
          ch_next      = spi_rx_data[7:6];
          reg_sel_next = spi_rx_data[5:4];
          case (spi_rx_data[3:0])
            4'h2:    state_next = RD1;
            4'h3:    state_next = WR1;
            4'h4:    state_next = TX1;
            4'h5:    state_next = RX1;
            4'h6:    state_next = START;
            4'hF:    state_next = RESET;
            default: state_next = IDLE;
          endcase
        end
        RD1: begin
          spi_tx_data_next   = read_byte;
          spi_tx_strobe_next = 1'b1;
          state_next         = RD2;
        end
        RD2: if (spi_rx_strobe) state_next = RD1;
        WR1: if (spi_rx_strobe) begin
          mask_next  = spi_rx_data;
          state_next = WR2;
        end
        WR2: if (spi_rx_strobe) begin
          if (reg_sel_reg == 2'd2) begin
            for (int i = 0; i < CHANNELS; i++) begin
              if (ch_sel[i]) begin
                control_next[i*8 +: 8] = (control_reg[i*8 +: 8] & ~mask_reg) |
                                         (spi_rx_data & mask_reg);
              end
            end
          end
          state_next = IDLE;
        end
        TX1: begin
          tx_clear   = ch_sel;
          state_next = TX2;
        end
        TX2: if (spi_rx_strobe) begin
          tx_data_next[DATA_WIDTH-1:8] = spi_rx_data[DATA_WIDTH-9:0];
          word_valid_next              = ~full_sel;
          spi_tx_data_next             = full_sel ? 8'h81 : 8'h00;
          spi_tx_strobe_next           = 1'b1;
          state_next                   = TX3;
        end
        TX3: if (spi_rx_strobe) begin
          tx_data_next[7:0] = spi_rx_data;
          if (word_valid_reg) tx_load_next = ch_sel;
          state_next = TX2;
        end
        RX1: begin
          // Data sits in the low bits; flags occupy the top two bits.
          rx_buf_next                 = '0;
          rx_buf_next[DATA_WIDTH-1:0] = rx_data_sel;
          rx_buf_next[15]             = rx_error_sel;
          rx_buf_next[14]             = rx_empty_sel;
          state_next                  = RX2;
        end
        RX2: begin
          spi_tx_data_next   = rx_buf_reg[15:8];
          spi_tx_strobe_next = 1'b1;
          state_next         = RX3;
        end
        RX3: if (spi_rx_strobe) begin
          spi_tx_data_next   = rx_buf_reg[7:0];
          spi_tx_strobe_next = 1'b1;
          if (rx_buf_reg[15])      rx_reset_next = ch_sel;
          else if (!rx_buf_reg[14]) rx_read_next = ch_sel;
          state_next = RX4;
        end
        RX4: if (spi_rx_strobe) state_next = RX1;
        START: begin
          if (!empty_sel && !active_sel) tx_start_next = ch_sel;
          state_next = IDLE;
        end
        RESET: begin
          tx_reset_next = ch_sel;
          rx_reset_next = ch_sel;
          tx_clear      = ch_sel;
          state_next    = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
    // A falling tx_active sets completion and wins over a same-cycle clear.
    tx_complete_next = (tx_complete_reg & ~tx_clear) | (tx_active_d_reg & ~tx_active);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs_meta_reg       <= 1'b1;
      cs_sync_reg       <= 1'b1;
      state_reg         <= IDLE;
      ch_reg            <= 2'd0;
      reg_sel_reg       <= 2'd0;
      mask_reg          <= 8'h00;
      word_valid_reg    <= 1'b0;
      rx_buf_reg        <= 16'h0000;
      control_reg       <= {CHANNELS{DEFAULT_CONTROL}};
      tx_complete_reg   <= '0;
      tx_active_d_reg   <= '0;
      spi_tx_data_reg   <= 8'h00;
      spi_tx_strobe_reg <= 1'b0;
      tx_data_reg       <= '0;
      tx_load_reg       <= '0;
      tx_start_reg      <= '0;
      tx_reset_reg      <= '0;
      rx_reset_reg      <= '0;
      rx_read_reg       <= '0;
    end else begin
      cs_meta_reg       <= spi_cs_n;
      cs_sync_reg       <= cs_meta_reg;
      state_reg         <= state_next;
      ch_reg            <= ch_next;
      reg_sel_reg       <= reg_sel_next;
      mask_reg          <= mask_next;
      word_valid_reg    <= word_valid_next;
      rx_buf_reg        <= rx_buf_next;
      control_reg       <= control_next;
      tx_complete_reg   <= tx_complete_next;
      tx_active_d_reg   <= tx_active;
      spi_tx_data_reg   <= spi_tx_data_next;
      spi_tx_strobe_reg <= spi_tx_strobe_next;
      tx_data_reg       <= tx_data_next;
      tx_load_reg       <= tx_load_next;
      tx_start_reg      <= tx_start_next;
      tx_reset_reg      <= tx_reset_next;
      rx_reset_reg      <= rx_reset_next;
      rx_read_reg       <= rx_read_next;
    end
  end

  assign spi_tx_data     = spi_tx_data_reg;
  assign spi_tx_strobe   = spi_tx_strobe_reg;
  assign tx_data         = tx_data_reg;
  assign tx_load_strobe  = tx_load_reg;
  assign tx_start_strobe = tx_start_reg;
  assign tx_reset        = tx_reset_reg;
  assign rx_reset        = rx_reset_reg;
  assign rx_read_strobe  = rx_read_reg;
  assign control         = control_reg;

endmodule

// File: tb/tb_multi_channel_control.sv
// tb_multi_channel_control: scoreboard bench for multi_channel_control.
// Expected SPI reply bytes are queued as commands are sent and popped as the
// DUT strobes spi_tx_data; strobe pulses are counted per channel.
module tb_multi_channel_control;
  localparam int CH = 2;
  localparam int DW = 10;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             spi_cs_n;
  logic [7:0]       spi_rx_data;
  logic             spi_rx_strobe;
  logic [7:0]       spi_tx_data;
  logic             spi_tx_strobe;
  logic [CH-1:0]    tx_reset, tx_active, tx_load_strobe, tx_start_strobe, tx_empty, tx_full;
  logic [DW-1:0]    tx_data;
  logic [CH-1:0]    rx_reset, rx_active, rx_error, rx_read_strobe, rx_empty;
  logic [CH*DW-1:0] rx_data;
  logic [CH*8-1:0]  control;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int load_cnt = 0, start_cnt = 0, rd_cnt = 0, rxrst_cnt = 0, txrst_cnt = 0;
  logic [DW-1:0] last_load;

  multi_channel_control #(.CHANNELS(CH), .DATA_WIDTH(DW), .DEFAULT_CONTROL(8'h48)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_cs_n(spi_cs_n), .spi_rx_data(spi_rx_data), .spi_rx_strobe(spi_rx_strobe),
    .spi_tx_data(spi_tx_data), .spi_tx_strobe(spi_tx_strobe),
    .tx_reset(tx_reset), .tx_active(tx_active), .tx_data(tx_data),
    .tx_load_strobe(tx_load_strobe), .tx_start_strobe(tx_start_strobe),
    .tx_empty(tx_empty), .tx_full(tx_full),
    .rx_reset(rx_reset), .rx_active(rx_active), .rx_error(rx_error),
    .rx_data(rx_data), .rx_read_strobe(rx_read_strobe), .rx_empty(rx_empty),
    .control(control)
  );

  always #5 clk = ~clk;

  // Scoreboard pop on each reply strobe, and strobe pulse counters.
  always @(negedge clk) begin
    if (reset_n) begin
      if (spi_tx_strobe) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL spi_reply unexpected: got %h, none required", spi_tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (spi_tx_data !== exp_b) begin
            miscompares++;
            $display("FAIL spi_reply: got %h, required %h", spi_tx_data, exp_b);
          end else $display("reply %h ok", spi_tx_data);
        end
      end
      if (tx_load_strobe[0]) begin load_cnt++; last_load = tx_data; end
      if (tx_start_strobe[0]) start_cnt++;
      if (rx_read_strobe[1]) rd_cnt++;
      if (rx_reset[1]) rxrst_cnt++;
      if (tx_reset[1]) txrst_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_rx_data = b;
    spi_rx_strobe = 1'b1;
    @(posedge clk); #1;
    spi_rx_strobe = 1'b0;
  endtask

  task automatic cs_cycle();
    spi_cs_n = 1'b1;
    idle(4);
    spi_cs_n = 1'b0;
    idle(4);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end else $display("%s = %0d ok", name, got);
  endtask

  task automatic test_reset();
    idle(3);
    @(negedge clk);
    vectors++;
    if (control !== 16'h4848) begin miscompares++; $display("FAIL reset_control: got %h, required 4848", control); end
    vectors++;
    if ({spi_tx_strobe, spi_tx_data, tx_data} !== 19'd0) begin
      miscompares++; $display("FAIL reset_data: got %h/%h/%h, required 0", spi_tx_strobe, spi_tx_data, tx_data);
    end
    vectors++;
    if ({tx_reset, tx_load_strobe, tx_start_strobe, rx_reset, rx_read_strobe} !== 10'd0) begin
      miscompares++; $display("FAIL reset_strobes: got %b, required 0",
        {tx_reset, tx_load_strobe, tx_start_strobe, rx_reset, rx_read_strobe});
    end else $display("reset outputs ok");
    reset_n = 1'b1;
    spi_cs_n = 1'b0;
    idle(4);
  endtask

  task automatic test_read();
    exp_q.push_back(8'h48);
    send_byte(8'h22);
    @(negedge clk);
    vectors++;
    if (spi_tx_strobe !== 1'b0) begin miscompares++; $display("FAIL read_early: got %b, required 0", spi_tx_strobe); end
    @(negedge clk);
    vectors++;
    if (spi_tx_strobe !== 1'b1) begin miscompares++; $display("FAIL read_latency: got %b, required 1", spi_tx_strobe); end
    idle(2);
    exp_q.push_back(8'h48);
    send_byte(8'h00);
    idle(4);
    cs_cycle();
    exp_q.push_back(8'hA5);
    send_byte(8'h32);
    idle(4);
    cs_cycle();
    exp_q.push_back(8'h00);
    send_byte(8'hA2);
    idle(4);
    cs_cycle();
    check_int("read_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_write();
    send_byte(8'h63); idle(2);
    send_byte(8'h01); idle(2);
    send_byte(8'hFF); idle(2);
    vectors++;
    if (control !== 16'h4948) begin miscompares++; $display("FAIL write_ctrl: got %h, required 4948", control); end
    else $display("write control %h ok", control);
    send_byte(8'h53); idle(2);
    send_byte(8'hFF); idle(2);
    send_byte(8'h00); idle(2);
    vectors++;
    if (control !== 16'h4948) begin miscompares++; $display("FAIL write_reg1_discard: got %h, required 4948", control); end
    exp_q.push_back(8'h49);
    send_byte(8'h62); idle(4);
    cs_cycle();
    check_int("write_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_tx();
    load_cnt = 0;
    tx_full = '0;
    send_byte(8'h04); idle(2);
    exp_q.push_back(8'h00);
    send_byte(8'h02); idle(3);
    send_byte(8'h5A); idle(3);
    check_int("tx_load_count", load_cnt, 1);
    vectors++;
    if (last_load !== 10'h25A) begin miscompares++; $display("FAIL tx_data: got %h, required 25a", last_load); end
    tx_full[0] = 1'b1;
    exp_q.push_back(8'h81);
    send_byte(8'h01); idle(3);
    send_byte(8'h23); idle(3);
    check_int("tx_full_no_load", load_cnt, 1);
    tx_full = '0;
    cs_cycle();
    check_int("tx_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_tx_complete();
    tx_active[0] = 1'b1;
    idle(3);
    send_byte(8'h04);
    tx_active[0] = 1'b0;
    idle(2);
    cs_cycle();
    exp_q.push_back(8'h08);
    send_byte(8'h12); idle(4);
    cs_cycle();
    send_byte(8'h04); idle(3);
    cs_cycle();
    exp_q.push_back(8'h00);
    send_byte(8'h12); idle(4);
    cs_cycle();
    rx_active[1] = 1'b1; rx_error[1] = 1'b1; tx_active[1] = 1'b1;
    idle(2);
    exp_q.push_back(8'h64);
    send_byte(8'h52); idle(4);
    cs_cycle();
    rx_active[1] = 1'b0; rx_error[1] = 1'b0; tx_active[1] = 1'b0;
    idle(2);
    check_int("status_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_rx();
    rd_cnt = 0; rxrst_cnt = 0;
    rx_data = '0;
    rx_data[2*DW-1:DW] = 10'h3C1;
    rx_empty[1] = 1'b0;
    exp_q.push_back(8'h03);
    send_byte(8'h45); idle(4);
    exp_q.push_back(8'hC1);
    send_byte(8'h00); idle(4);
    check_int("rx_read_count", rd_cnt, 1);
    check_int("rx_reset_count_ok", rxrst_cnt, 0);
    rx_error[1] = 1'b1;
    exp_q.push_back(8'h83);
    send_byte(8'h00); idle(4);
    exp_q.push_back(8'hC1);
    send_byte(8'h00); idle(4);
    check_int("rx_err_reset_count", rxrst_cnt, 1);
    check_int("rx_err_no_read", rd_cnt, 1);
    rx_error[1] = 1'b0;
    rx_empty[1] = 1'b1;
    cs_cycle();
    check_int("rx_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_start();
    start_cnt = 0;
    tx_empty[0] = 1'b0;
    send_byte(8'h06); idle(3);
    check_int("start_pulse", start_cnt, 1);
    tx_active[0] = 1'b1;
    send_byte(8'h06); idle(3);
    check_int("start_blocked_active", start_cnt, 1);
    tx_active[0] = 1'b0;
    tx_empty[0] = 1'b1;
    send_byte(8'h06); idle(3);
    check_int("start_blocked_empty", start_cnt, 1);
  endtask

  task automatic test_chan_reset();
    txrst_cnt = 0; rxrst_cnt = 0;
    exp_q.push_back(8'h08);
    send_byte(8'h52); idle(4);
    cs_cycle();
    send_byte(8'h4F); idle(3);
    check_int("chan_tx_reset", txrst_cnt, 1);
    check_int("chan_rx_reset", rxrst_cnt, 1);
    vectors++;
    if (control !== 16'h4948) begin miscompares++; $display("FAIL chan_reset_ctrl: got %h, required 4948", control); end
    exp_q.push_back(8'h00);
    send_byte(8'h52); idle(4);
    cs_cycle();
    check_int("chan_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_abort();
    load_cnt = 0;
    send_byte(8'h04); idle(2);
    exp_q.push_back(8'h00);
    send_byte(8'h02); idle(3);
    tx_empty[0] = 1'b0;
    start_cnt = 0;
    spi_cs_n = 1'b1;
    idle(3);
    spi_cs_n = 1'b0;
    idle(3);
    tx_empty[0] = 1'b1;
    idle(2);
    vectors++;
`ifdef CONTROL_TX_AUTOSTART_EN
    if (start_cnt == 0) begin miscompares++; $display("FAIL abort_autostart: got %0d, required >0", start_cnt); end
`else
    if (start_cnt != 0) begin miscompares++; $display("FAIL abort_no_start: got %0d, required 0", start_cnt); end
`endif
    exp_q.push_back(8'h49);
    send_byte(8'h62); idle(4);
    check_int("abort_no_load", load_cnt, 0);
    cs_cycle();
    check_int("abort_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_reset_mid();
    load_cnt = 0;
    send_byte(8'h04); idle(2);
    exp_q.push_back(8'h00);
    send_byte(8'h02); idle(3);
    reset_n = 1'b0;
    idle(1);
    @(negedge clk);
    vectors++;
    if (control !== 16'h4848) begin miscompares++; $display("FAIL midreset_ctrl: got %h, required 4848", control); end
    reset_n = 1'b1;
    idle(4);
    send_byte(8'h5A); idle(3);
    check_int("midreset_no_load", load_cnt, 0);
    exp_q.push_back(8'h48);
    send_byte(8'h22); idle(4);
    cs_cycle();
    check_int("midreset_queue_left", exp_q.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0; spi_cs_n = 1'b1; spi_rx_data = 8'h00; spi_rx_strobe = 1'b0;
    tx_active = '0; tx_empty = '1; tx_full = '0;
    rx_active = '0; rx_error = '0; rx_empty = '1; rx_data = '0;
    test_reset();
    test_read();
    test_write();
    test_tx();
    test_tx_complete();
    test_rx();
    test_start();
    test_chan_reset();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
